eim_mac_accum: RTL and testbench
================================

// Module: eim_mac_accum
// PURPOSE
//  Accumulates the stream of unsigned 2*WIDTH-bit products from the EIM approximate multiplier into one dot-product sum.
//  Sits directly downstream of the multiplier inside the APTPU processing element.
//  One product is accepted per cycle; a group is closed by prod_last.
//  The finished sum is presented on a valid/ready output port and held until it is taken.
// PARAMETERS
//  PROD_W  64  product width; equals 2*WIDTH of the multiplier feeding this block
//  GUARD   8   guard bits; ACC_W = PROD_W+GUARD
//  CNT_W   16  width of the beat counter
//  SAT     1   1: saturate the accumulator at all-ones; 0: wrap modulo 2^ACC_W
// PORTS
//  clk         in   1        clock
//  rst         in   1        synchronous, active-high reset
//  clear       in   1        abort the partial group and zero the accumulator
//  prod_valid  in   1        product beat valid
//  prod_ready  out  1        block can accept a product beat
//  prod        in   PROD_W   unsigned product R from the multiplier
//  prod_last   in   1        marks the final beat of the group
//  out_valid   out  1        sum is available
//  out_ready   in   1        consumer accepts the sum
//  out_sum     out  ACC_W    accumulated sum
//  out_count   out  CNT_W    number of beats in the group
//  out_ovf     out  1        sticky: the group saturated or wrapped
// BEHAVIOUR
//  Reset: on rst=1 at a clk edge, the block goes to IDLE, the accumulator and counter are zeroed, and ovf is cleared.
//   Output values after reset: out_valid=0, out_sum=0, out_count=0, out_ovf=0, prod_ready=1.
//   rst overrides every other input and aborts any operation in progress.
//  States (package enum acc_state_t):
//   IDLE   accumulator=0, waiting for the first beat
//   ACCUM  group in progress
//   HOLD   result presented on the output
//  Handshake rules:
//   Beat accepted = prod_valid & prod_ready. prod_ready=1 in IDLE and ACCUM, 0 in HOLD.
//   Output transfer = out_valid & out_ready. out_valid=1 only in HOLD.
//   While out_valid=1, out_sum, out_count and out_ovf are held stable.
//  Per accepted beat:
//   acc <= acc + zero-extended prod (ACC_W-bit add).
//   cnt <= cnt+1, saturating at 2^CNT_W-1.
//  Overflow:
//   If the add carries out of ACC_W: with SAT=1, acc <= all-ones; with SAT=0, the result wraps.
//   In both cases ovf <= 1, and ovf stays set until the group ends.
//  Transitions:
//   IDLE  -> ACCUM on an accepted beat with prod_last=0.
//   IDLE  -> HOLD  on an accepted beat with prod_last=1 (single-beat group).
//   ACCUM -> HOLD  on an accepted beat with prod_last=1.
//   HOLD  -> IDLE  on an output transfer; acc, cnt and ovf are zeroed in the same edge.
//  Latency: out_valid rises on the cycle after the last beat is accepted.
//   out_sum includes that last beat.
//   HOLD always costs at least one cycle, so at least one bubble occurs between groups.
//  clear:
//   In IDLE or ACCUM: next state is IDLE, acc/cnt/ovf are zeroed, and a beat presented in the same cycle is dropped.
//   In HOLD: clear is ignored; the result must still be delivered.
//  prod_valid=0 cycles inside a group are allowed; acc is held unchanged.
//  Output is registered; there is no combinational path from prod to out_*.
// STRUCTURE
//  Package eim_pkg holds:
//   acc_state_t (IDLE/ACCUM/HOLD)
//   default constants EIM_WIDTH=32, EIM_PROD_W=2*EIM_WIDTH, EIM_GUARD=8
//  No sub-module. A local function sat_add(acc, prod) returns {sum, carry}.
//  This is a single always_ff block plus combinational ready/valid logic.
// TESTING
//  1. 4 beats prod=3,5,7,11, last on beat 4 -> out_sum=26, out_count=4, out_ovf=0; out_valid 1 cycle after beat 4.
//  2. Single beat prod=0xFFFF_FFFF_FFFF_FFFF with last -> out_sum=0x00_FFFF_FFFF_FFFF_FFFF, out_count=1.
//  3. SAT=1, 257 beats of all-ones -> out_sum=all-ones (72b), out_ovf=1.
//     SAT=0, same stimulus -> out_sum wraps (modulo 2^72), out_ovf=1.
//  4. Hold out_ready=0 for 5 cycles in HOLD, with prod_valid=1 throughout
//     -> prod_ready=0, outputs stable, no beat lost; the next group starts only after the transfer.
//  5. 2 beats (10,20), then clear with a beat of 99 in the same cycle, then 1 beat 4 with last -> out_sum=4, out_count=1.
//  6. rst asserted mid-group after 3 beats -> next cycle all outputs 0, prod_ready=1, state IDLE; a new group sums from 0.

Source files
------------

// File: rtl/eim_pkg.sv
// rtl/eim_pkg.sv - shared types and default widths for the EIM MAC accumulator
package eim_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } acc_state_t;

  localparam int EIM_WIDTH  = 32;
  localparam int EIM_PROD_W = 2 * EIM_WIDTH;
  localparam int EIM_GUARD  = 8;

endpackage

// File: rtl/eim_mac_accum.sv
// rtl/eim_mac_accum.sv - accumulates EIM multiplier products into one dot-product sum per group
module eim_mac_accum
  import eim_pkg::*;
#(
  parameter int PROD_W = EIM_PROD_W,
  parameter int GUARD  = EIM_GUARD,
  parameter int CNT_W  = 16,
  parameter bit SAT    = 1'b1,
  parameter int ACC_W  = PROD_W + GUARD
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              prod_valid,
  output logic              prod_ready,
  input  logic [PROD_W-1:0] prod,
  input  logic              prod_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_ovf
);

  acc_state_t       state, state_nx;
  logic [ACC_W-1:0] acc, acc_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             ovf, ovf_nx;
  logic [ACC_W:0]   add_res;
  logic             beat;

  // Returns {sum, carry}; with SAT the sum pins at all-ones when the add carries out.
  function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] a,
                                             input logic [PROD_W-1:0] p);
    logic [ACC_W:0] s;
    s = {1'b0, a} + {{(GUARD + 1){1'b0}}, p};
    if (SAT && s[ACC_W]) return {{ACC_W{1'b1}}, 1'b1};
    return {s[ACC_W-1:0], s[ACC_W]};
  endfunction

  assign prod_ready = (state != HOLD);
  assign out_valid  = (state == HOLD);
  assign beat       = prod_valid & prod_ready;
  assign add_res    = sat_add(acc, prod);

  assign out_sum   = acc;
  assign out_count = cnt;
  assign out_ovf   = ovf;

  always_comb begin
    state_nx = state;
    acc_nx   = acc;
    cnt_nx   = cnt;
    ovf_nx   = ovf;
    case (state)
      IDLE, ACCUM: begin
        if (clear) begin
          state_nx = IDLE;
          acc_nx   = '0;
          cnt_nx   = '0;
          ovf_nx   = 1'b0;
        end else if (beat) begin
          acc_nx   = add_res[ACC_W:1];
          cnt_nx   = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + CNT_W'(1);
          ovf_nx   = ovf | add_res[0];
          state_nx = prod_last ? HOLD : ACCUM;
        end
      end
      HOLD: begin
        // clear is deliberately ignored here so a finished result is never lost.
        if (out_ready) begin
          state_nx = IDLE;
          acc_nx   = '0;
          cnt_nx   = '0;
          ovf_nx   = 1'b0;
        end
      end
      default: begin
        state_nx = IDLE;
        acc_nx   = '0;
        cnt_nx   = '0;
        ovf_nx   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      ovf   <= 1'b0;
    end else begin
      state <= state_nx;
      acc   <= acc_nx;
      cnt   <= cnt_nx;
      ovf   <= ovf_nx;
    end
  end

endmodule

// File: tb/tb_eim_mac_accum.sv
// tb/tb_eim_mac_accum.sv - directed self-checking bench for eim_mac_accum (saturating and wrapping builds)
module tb_eim_mac_accum;

  logic        clk = 1'b0;
  logic        rst, clear, prod_valid, prod_last, out_ready;
  logic [63:0] prod;

  logic        ready_a, valid_a, ovf_a;
  logic [71:0] sum_a;
  logic [15:0] cnt_a;
  logic        ready_b, valid_b, ovf_b;
  logic [71:0] sum_b;
  logic [7:0]  cnt_b;

  int n_checks = 0;
  int n_fail   = 0;

  eim_mac_accum #(.PROD_W(64), .GUARD(8), .CNT_W(16), .SAT(1'b1)) dut_a (
    .clk(clk), .rst(rst), .clear(clear),
    .prod_valid(prod_valid), .prod_ready(ready_a), .prod(prod), .prod_last(prod_last),
    .out_valid(valid_a), .out_ready(out_ready),
    .out_sum(sum_a), .out_count(cnt_a), .out_ovf(ovf_a)
  );

  eim_mac_accum #(.PROD_W(64), .GUARD(8), .CNT_W(8), .SAT(1'b0)) dut_b (
    .clk(clk), .rst(rst), .clear(clear),
    .prod_valid(prod_valid), .prod_ready(ready_b), .prod(prod), .prod_last(prod_last),
    .out_valid(valid_b), .out_ready(out_ready),
    .out_sum(sum_b), .out_count(cnt_b), .out_ovf(ovf_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [63:0] p, input logic last);
    prod_valid = 1'b1;
    prod       = p;
    prod_last  = last;
    step();
    prod_valid = 1'b0;
    prod_last  = 1'b0;
  endtask

  task automatic take();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic chk_both(input string tag, input logic [71:0] s, input logic [15:0] c,
                          input logic o);
    chk({tag, "_valid_a"}, valid_a, 1'b1);
    chk({tag, "_sum_a"}, sum_a, s);
    chk({tag, "_cnt_a"}, cnt_a, c);
    chk({tag, "_ovf_a"}, ovf_a, o);
    chk({tag, "_valid_b"}, valid_b, 1'b1);
    chk({tag, "_sum_b"}, sum_b, s);
    chk({tag, "_cnt_b"}, cnt_b, c[7:0]);
    chk({tag, "_ovf_b"}, ovf_b, o);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_valid_a"}, valid_a, 1'b0);
    chk({tag, "_sum_a"}, sum_a, 72'd0);
    chk({tag, "_cnt_a"}, cnt_a, 16'd0);
    chk({tag, "_ovf_a"}, ovf_a, 1'b0);
    chk({tag, "_ready_a"}, ready_a, 1'b1);
    chk({tag, "_valid_b"}, valid_b, 1'b0);
    chk({tag, "_sum_b"}, sum_b, 72'd0);
    chk({tag, "_ready_b"}, ready_b, 1'b1);
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; prod_valid = 1'b0; prod_last = 1'b0; out_ready = 1'b0; prod = '0;
    step();
    step();
    rst = 1'b0;
    chk_idle("reset");

    // 1: four beats 3+5+7+11
    send(64'd3, 1'b0);
    send(64'd5, 1'b0);
    send(64'd7, 1'b0);
    chk("t1_no_valid_early", valid_a, 1'b0);
    chk("t1_mid_sum", sum_a, 72'd15);
    send(64'd11, 1'b1);
    chk_both("t1", 72'd26, 16'd4, 1'b0);
    chk("t1_ready_hold", ready_a, 1'b0);
    take();
    chk_idle("t1_after");

    // 2: single maximal product
    send(64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    chk_both("t2", 72'h00_FFFF_FFFF_FFFF_FFFF, 16'd1, 1'b0);
    take();

    // 3: 257 all-ones beats overflow 72 bits on the final beat
    for (int i = 0; i < 256; i++) send(64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    chk("t3_pre_sum_a", sum_a, 72'hFF_FFFF_FFFF_FFFF_FF00);
    chk("t3_pre_ovf_a", ovf_a, 1'b0);
    chk("t3_pre_cnt_b", cnt_b, 8'd255);
    send(64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    chk("t3_valid_a", valid_a, 1'b1);
    chk("t3_sum_sat", sum_a, 72'hFF_FFFF_FFFF_FFFF_FFFF);
    chk("t3_ovf_sat", ovf_a, 1'b1);
    chk("t3_cnt_a", cnt_a, 16'd257);
    chk("t3_sum_wrap", sum_b, 72'h00_FFFF_FFFF_FFFF_FEFF);
    chk("t3_ovf_wrap", ovf_b, 1'b1);
    chk("t3_cnt_b_sat", cnt_b, 8'd255);
    take();
    chk("t3_ovf_cleared", ovf_a, 1'b0);

    // 4: stalled output with a beat waiting
    send(64'd1, 1'b0);
    send(64'd2, 1'b1);
    prod_valid = 1'b1; prod = 64'd100; prod_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("t4_ready_low", ready_a, 1'b0);
      chk("t4_valid", valid_a, 1'b1);
      chk("t4_sum_stable", sum_a, 72'd3);
      chk("t4_cnt_stable", cnt_a, 16'd2);
      step();
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("t4_transfer_valid", valid_a, 1'b0);
    chk("t4_transfer_sum", sum_a, 72'd0);
    chk("t4_ready_back", ready_a, 1'b1);
    step();
    prod_valid = 1'b0; prod_last = 1'b0;
    chk_both("t4_next", 72'd100, 16'd1, 1'b0);
    take();

    // 5: clear drops the partial group and the beat alongside it
    send(64'd10, 1'b0);
    send(64'd20, 1'b0);
    clear = 1'b1; prod_valid = 1'b1; prod = 64'd99; prod_last = 1'b0;
    step();
    clear = 1'b0; prod_valid = 1'b0;
    chk_idle("t5_cleared");
    send(64'd4, 1'b1);
    chk_both("t5", 72'd4, 16'd1, 1'b0);
    take();

    // 6: reset mid-group
    send(64'd1, 1'b0);
    send(64'd2, 1'b0);
    send(64'd3, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_idle("t6_reset");
    send(64'd6, 1'b0);
    send(64'd7, 1'b1);
    chk_both("t6", 72'd13, 16'd2, 1'b0);
    take();
    chk_idle("t6_after");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
